decode_stage_param: RTL and testbench
=====================================

Name: decode_stage_param

Overview:
- Parametrised ID stage for the RISC-V pipeline.
- Holds the integer register file and generates all RV32I immediates (R/I/S/B/U/J).
- Resolves all six conditional branch types in ID, using forwarded operands.
- Drives a valid/ready ID/EX pipeline register with stall and flush, between IF/ID and the EX stage.

Parameters:
- XLEN, 32, datapath/register width (32 or 64).
- NREG, 32, architectural register count (16 or 32); AW = $clog2(NREG).
- RF_INIT_INDEX, 0, if 1 register xi resets to value i (x0 still 0); if 0 all reset to 0.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_pc  in  XLEN  PC of the IF/ID instruction.
- if_inst  in  32  IF/ID instruction.
- id_ready  out  1  stage accepts the IF/ID instruction this cycle.
- flush  in  1  kill the instruction entering ID/EX.
- ex_ready  in  1  EX accepts ID/EX contents.
- wb_we, wb_rd, wb_data  in  1/AW/XLEN  register write port.
- fwd_sel1, fwd_sel2  in  2/2  00 = RF, 01 = ex_alu_out, 10 = mem result, 11 = RF.
- ex_alu_out, mem_alu_out, mem_rdata  in  XLEN  forwarding sources.
- mem_stage_to_reg  in  1  mem result = mem_rdata when 1, else mem_alu_out.
- imm_sel  in  3  001 R, 010 I, 011 S, 100 B, 101 J, 110 U, others give 0.
- ctrl_sel, mem_read, mem_to_reg, reg_write, alu_src, mem_write  in  1 each  control from the main decoder.
- alu_op  in  2  ALU op class.
- br_taken  out  1  conditional branch resolved taken (combinational).
- pc_branch  out  XLEN  if_pc + imm (combinational).
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_data1, ex_data2, ex_imm  out  XLEN  registered operands and immediate.
- ex_rs1, ex_rs2, ex_rd  out  AW  registered register indices.
- ex_func  out  4  {inst[30], inst[14:12]}.
- ex_mem_read, ex_mem_to_reg, ex_reg_write, ex_alu_src, ex_mem_write  out  1  registered control.
- ex_alu_op  out  2  registered ALU op class.

Behaviour:
- Reset: every ex_* output is 0 (including ex_valid). RF contents follow RF_INIT_INDEX.
- Register file:
  - Two combinational reads at if_inst[19:15] and [24:20], truncated to AW bits.
  - Write on the clock edge when wb_we and wb_rd != 0.
  - x0 always reads 0.
  - Same-cycle read/write of the same register returns the old value (see optional feature).
- Operand mux: the fwd_sel encoding above applies to both operands. Outputs data1 and data2.
- Immediates: sign-extended from inst[31] to XLEN.
  - B and J have bit 0 = 0.
  - U = {inst[31:12], 12'b0}, sign-extended.
- Branch compare:
  - br_taken = if_valid & (inst[6:0] == 1100011) & cond.
  - cond is selected by funct3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - 010 and 011 give cond = 0.
- pc_branch wraps modulo 2^XLEN.
- Handshake:
  - id_ready = !ex_valid | ex_ready.
  - load = id_ready.
  - On load, ID/EX captures all fields. ex_valid <= if_valid & ~flush.
  - Control fields are forced to 0 when ctrl_sel = 0, if_valid = 0 or flush = 1.
  - When !load, all ID/EX contents hold. Back-pressure never corrupts them.
- flush with !load: ex_valid and all control outputs clear on the next edge. Data fields hold.
- Latency: 1 cycle from IF/ID to ID/EX.
- Reset asserted mid-stall: outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read of the register being written this cycle (wb_we, wb_rd != 0) returns wb_data, so no WB→ID hazard is possible.
- Undefined: the read returns the pre-write value. The hazard unit then must forward or stall.

Test Plan:
- Reset with RF_INIT_INDEX=1: read x5 and x0 → data1 = 5, data2 = 0. All ex_* outputs are 0 during reset.
- Write x3 = 0xDEADBEEF, then write x0 = 0x1234. Reads of x3 and x0 → 0xDEADBEEF and 0.
- BLT with x1 = 0xFFFFFFFF, x2 = 1 → br_taken = 1. BLTU with the same operands → br_taken = 0. pc_branch = if_pc + sign-extended B immediate (imm -8 with if_pc 0x100 gives 0x0F8).
- ex_ready = 0 for 3 cycles with a new if_inst each cycle:
  - ID/EX outputs hold.
  - id_ready = 0.
  - On release, the next instruction is captured in one cycle.
- flush on a valid lw → next cycle ex_valid = 0 and ex_mem_read = 0.
- Same-cycle write and read of x7 = 0x55 → data1 = 0x55 with REGFILE_BYPASS_EN defined, the old value without it.

Source files
------------

// File: rtl/decode_stage_param.sv
// ID stage: register file, immediate generation and branch resolution, feeding a valid/ready ID/EX register.
// Latency 1 cycle; ID/EX holds while !ex_ready (id_ready low). REGFILE_BYPASS_EN makes reads see the same-cycle WB write.
module decode_stage_param #(
   parameter  int XLEN          = 32,
   parameter  int NREG          = 32,
   parameter  int RF_INIT_INDEX = 0,
   localparam int AW            = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_inst,
   output logic            id_ready,
   input  logic            flush,
   input  logic            ex_ready,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [1:0]      fwd_sel1,
   input  logic [1:0]      fwd_sel2,
   input  logic [XLEN-1:0] ex_alu_out,
   input  logic [XLEN-1:0] mem_alu_out,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_stage_to_reg,
   input  logic [2:0]      imm_sel,
   input  logic            ctrl_sel,
   input  logic            mem_read,
   input  logic            mem_to_reg,
   input  logic            reg_write,
   input  logic            alu_src,
   input  logic            mem_write,
   input  logic [1:0]      alu_op,
   output logic            br_taken,
   output logic [XLEN-1:0] pc_branch,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_data1,
   output logic [XLEN-1:0] ex_data2,
   output logic [XLEN-1:0] ex_imm,
   output logic [AW-1:0]   ex_rs1,
   output logic [AW-1:0]   ex_rs2,
   output logic [AW-1:0]   ex_rd,
   output logic [3:0]      ex_func,
   output logic            ex_mem_read,
   output logic            ex_mem_to_reg,
   output logic            ex_reg_write,
   output logic            ex_alu_src,
   output logic            ex_mem_write,
   output logic [1:0]      ex_alu_op
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] data1;
      logic [XLEN-1:0] data2;
      logic [XLEN-1:0] imm;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
      logic [3:0]      func;
      logic            mem_read;
      logic            mem_to_reg;
      logic            reg_write;
      logic            alu_src;
      logic            mem_write;
      logic [1:0]      alu_op;
   } idex_t;

   logic [XLEN-1:0] rf_q [NREG];
   logic [AW-1:0]   rs1, rs2, rd;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rf_rd1, rf_rd2, mem_res, data1, data2, imm;
   logic [31:0]     imm32;
   logic            cond, ctrl_ok;
   idex_t           idex_d, idex_q;

   assign rs1    = if_inst[15 +: AW];
   assign rs2    = if_inst[20 +: AW];
   assign rd     = if_inst[7 +: AW];
   assign funct3 = if_inst[14:12];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= (RF_INIT_INDEX != 0) ? XLEN'(i) : '0;
      end else if (wb_we && wb_rd != '0) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      rf_rd1 = (rs1 == '0) ? '0 : rf_q[rs1];
      rf_rd2 = (rs2 == '0) ? '0 : rf_q[rs2];
`ifdef REGFILE_BYPASS_EN
      if (wb_we && wb_rd != '0 && wb_rd == rs1) rf_rd1 = wb_data;
      if (wb_we && wb_rd != '0 && wb_rd == rs2) rf_rd2 = wb_data;
`endif
   end

   // Encodings 00 and 11 both select the register file.
   assign mem_res = mem_stage_to_reg ? mem_rdata : mem_alu_out;

   always_comb begin
      case (fwd_sel1)
         2'b01:   data1 = ex_alu_out;
         2'b10:   data1 = mem_res;
         default: data1 = rf_rd1;
      endcase
      case (fwd_sel2)
         2'b01:   data2 = ex_alu_out;
         2'b10:   data2 = mem_res;
         default: data2 = rf_rd2;
      endcase
   end

   always_comb begin
      case (imm_sel)
         3'b010:  imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
         3'b011:  imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
         3'b100:  imm32 = {{20{if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
         3'b101:  imm32 = {{12{if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
         3'b110:  imm32 = {if_inst[31:12], 12'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

   always_comb begin
      case (funct3)
         3'b000:  cond = (data1 == data2);
         3'b001:  cond = (data1 != data2);
         3'b100:  cond = ($signed(data1) <  $signed(data2));
         3'b101:  cond = ($signed(data1) >= $signed(data2));
         3'b110:  cond = (data1 <  data2);
         3'b111:  cond = (data1 >= data2);
         default: cond = 1'b0;
      endcase
   end

   assign br_taken  = if_valid && (if_inst[6:0] == 7'b1100011) && cond;
   assign pc_branch = if_pc + imm;

   assign id_ready = !idex_q.valid || ex_ready;
   assign ctrl_ok  = ctrl_sel && if_valid && !flush;

   // A flush during a stall kills the held instruction but leaves its data fields alone.
   always_comb begin
      idex_d = idex_q;
      if (id_ready) begin
         idex_d.valid      = if_valid && !flush;
         idex_d.data1      = data1;
         idex_d.data2      = data2;
         idex_d.imm        = imm;
         idex_d.rs1        = rs1;
         idex_d.rs2        = rs2;
         idex_d.rd         = rd;
         idex_d.func       = {if_inst[30], funct3};
         idex_d.mem_read   = ctrl_ok && mem_read;
         idex_d.mem_to_reg = ctrl_ok && mem_to_reg;
         idex_d.reg_write  = ctrl_ok && reg_write;
         idex_d.alu_src    = ctrl_ok && alu_src;
         idex_d.mem_write  = ctrl_ok && mem_write;
         idex_d.alu_op     = ctrl_ok ? alu_op : 2'b00;
      end else if (flush) begin
         idex_d.valid      = 1'b0;
         idex_d.mem_read   = 1'b0;
         idex_d.mem_to_reg = 1'b0;
         idex_d.reg_write  = 1'b0;
         idex_d.alu_src    = 1'b0;
         idex_d.mem_write  = 1'b0;
         idex_d.alu_op     = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) idex_q <= '0;
      else          idex_q <= idex_d;
   end

   assign ex_valid      = idex_q.valid;
   assign ex_data1      = idex_q.data1;
   assign ex_data2      = idex_q.data2;
   assign ex_imm        = idex_q.imm;
   assign ex_rs1        = idex_q.rs1;
   assign ex_rs2        = idex_q.rs2;
   assign ex_rd         = idex_q.rd;
   assign ex_func       = idex_q.func;
   assign ex_mem_read   = idex_q.mem_read;
   assign ex_mem_to_reg = idex_q.mem_to_reg;
   assign ex_reg_write  = idex_q.reg_write;
   assign ex_alu_src    = idex_q.alu_src;
   assign ex_mem_write  = idex_q.mem_write;
   assign ex_alu_op     = idex_q.alu_op;

endmodule

// File: tb/tb_decode_stage_param.sv
// Directed bench for decode_stage_param (XLEN=32, NREG=32, RF_INIT_INDEX=1) with an ID/EX scoreboard.
module tb_decode_stage_param;
   logic        clk = 1'b0;
   logic        reset_n, if_valid, id_ready, flush, ex_ready, wb_we;
   logic [31:0] if_pc, if_inst, wb_data, ex_alu_out, mem_alu_out, mem_rdata;
   logic [4:0]  wb_rd;
   logic [1:0]  fwd_sel1, fwd_sel2, alu_op;
   logic        mem_stage_to_reg, ctrl_sel, mem_read, mem_to_reg, reg_write, alu_src, mem_write;
   logic [2:0]  imm_sel;
   logic        br_taken, ex_valid;
   logic [31:0] pc_branch, ex_data1, ex_data2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_func;
   logic        ex_mem_read, ex_mem_to_reg, ex_reg_write, ex_alu_src, ex_mem_write;
   logic [1:0]  ex_alu_op;

   always #5 clk = ~clk;

   decode_stage_param #(.XLEN(32), .NREG(32), .RF_INIT_INDEX(1)) dut (
      .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .ex_alu_out(ex_alu_out),
      .mem_alu_out(mem_alu_out), .mem_rdata(mem_rdata), .mem_stage_to_reg(mem_stage_to_reg),
      .imm_sel(imm_sel), .ctrl_sel(ctrl_sel), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src(alu_src), .mem_write(mem_write), .alu_op(alu_op),
      .br_taken(br_taken), .pc_branch(pc_branch), .ex_valid(ex_valid), .ex_data1(ex_data1),
      .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_func(ex_func), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write),
      .ex_alu_op(ex_alu_op)
   );

   typedef struct {
      logic [31:0] d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  func;
      logic        mr, rw;
   } exp_t;

   exp_t sbq[$];
   int   npass = 0, nfail = 0, ntot = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [3:0] func, input logic mr, input logic rw);
      exp_t e;
      e.d1 = d1; e.d2 = d2; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.func = func; e.mr = mr; e.rw = rw;
      sbq.push_back(e);
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         ntot++;
         nfail++;
         $error("FAIL %s: scoreboard empty, got ex_valid %0b want an entry", tag, ex_valid);
         return;
      end
      e = sbq.pop_front();
      chk({tag, ".valid"}, 64'(ex_valid),     64'(1'b1));
      chk({tag, ".d1"},    64'(ex_data1),     64'(e.d1));
      chk({tag, ".d2"},    64'(ex_data2),     64'(e.d2));
      chk({tag, ".imm"},   64'(ex_imm),       64'(e.imm));
      chk({tag, ".rs1"},   64'(ex_rs1),       64'(e.rs1));
      chk({tag, ".rs2"},   64'(ex_rs2),       64'(e.rs2));
      chk({tag, ".rd"},    64'(ex_rd),        64'(e.rd));
      chk({tag, ".func"},  64'(ex_func),      64'(e.func));
      chk({tag, ".mr"},    64'(ex_mem_read),  64'(e.mr));
      chk({tag, ".rw"},    64'(ex_reg_write), 64'(e.rw));
   endtask

   function automatic logic [31:0] r_inst(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [2:0] f3);
      return {7'b0, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] b_inst(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] i_inst(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   // Branch seen in ID only for one half-cycle; if_valid drops before the next edge.
   task automatic br_check(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic v, input logic exp_taken, input logic [31:0] exp_pc);
      @(negedge clk);
      if_valid = v; if_inst = inst; if_pc = pc; imm_sel = 3'b100; ctrl_sel = 1'b0;
      #1;
      chk({tag, ".taken"}, 64'(br_taken),  64'(exp_taken));
      chk({tag, ".pc"},    64'(pc_branch), 64'(exp_pc));
      if_valid = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; flush = 1'b0; ex_ready = 1'b1;
      wb_we = 1'b0; wb_rd = '0; wb_data = '0; fwd_sel1 = 2'b00; fwd_sel2 = 2'b00;
      ex_alu_out = '0; mem_alu_out = '0; mem_rdata = '0; mem_stage_to_reg = 1'b0;
      imm_sel = 3'b000; ctrl_sel = 1'b0; mem_read = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
      alu_src = 1'b0; mem_write = 1'b0; alu_op = 2'b00;

      // Reset holds ID/EX at zero even with a valid instruction offered.
      @(negedge clk);
      if_valid = 1'b1; if_inst = r_inst(5'd0, 5'd5, 5'd9, 3'b000); ctrl_sel = 1'b1;
      reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1;
      alu_op = 2'b10; imm_sel = 3'b001;
      @(negedge clk);
      @(negedge clk);
      chk("rst.valid",  64'(ex_valid),      64'(1'b0));
      chk("rst.d1",     64'(ex_data1),      64'(32'h0));
      chk("rst.rd",     64'(ex_rd),         64'(5'h0));
      chk("rst.mr",     64'(ex_mem_read),   64'(1'b0));
      chk("rst.m2r",    64'(ex_mem_to_reg), 64'(1'b0));
      chk("rst.mw",     64'(ex_mem_write),  64'(1'b0));
      chk("rst.asrc",   64'(ex_alu_src),    64'(1'b0));
      chk("rst.aop",    64'(ex_alu_op),     64'(2'b00));
      chk("rst.idrdy",  64'(id_ready),      64'(1'b1));

      reset_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0; alu_src = 1'b0; mem_to_reg = 1'b0;
      push(32'd5, 32'd0, 32'd0, 5'd5, 5'd0, 5'd9, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      sb_check("x5x0");
      chk("x5x0.aop", 64'(ex_alu_op), 64'(2'b10));

      if_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("bubble.valid", 64'(ex_valid), 64'(1'b0));
      wb_rd = 5'd0; wb_data = 32'h1234;
      @(negedge clk);
      wb_rd = 5'd1; wb_data = 32'hFFFFFFFF;
      @(negedge clk);
      wb_rd = 5'd2; wb_data = 32'h1;
      @(negedge clk);
      wb_we = 1'b0; alu_op = 2'b00;
      if_valid = 1'b1; if_inst = r_inst(5'd0, 5'd3, 5'd10, 3'b000);
      push(32'hDEADBEEF, 32'd0, 32'd0, 5'd3, 5'd0, 5'd10, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      sb_check("x3x0");

      br_check("blt",  b_inst(13'h1FF8, 5'd2, 5'd1, 3'b100), 32'h100, 1'b1, 1'b1, 32'hF8);
      br_check("bltu", b_inst(13'h1FF8, 5'd2, 5'd1, 3'b110), 32'h100, 1'b1, 1'b0, 32'hF8);
      br_check("bge",  b_inst(13'h1FF8, 5'd2, 5'd1, 3'b101), 32'h100, 1'b1, 1'b0, 32'hF8);
      br_check("bgeu", b_inst(13'h0010, 5'd2, 5'd1, 3'b111), 32'h100, 1'b1, 1'b1, 32'h110);
      br_check("bne",  b_inst(13'h0010, 5'd2, 5'd1, 3'b001), 32'h100, 1'b1, 1'b1, 32'h110);
      br_check("f3_010", b_inst(13'h0010, 5'd1, 5'd1, 3'b010), 32'h100, 1'b1, 1'b0, 32'h110);
      br_check("noval", b_inst(13'h1FF8, 5'd2, 5'd1, 3'b100), 32'h100, 1'b0, 1'b0, 32'hF8);
      br_check("wrap", b_inst(13'h0008, 5'd1, 5'd1, 3'b000), 32'hFFFFFFFC, 1'b1, 1'b1, 32'h4);
      fwd_sel1 = 2'b01; ex_alu_out = 32'h1;
      br_check("fwd_ex", b_inst(13'h0010, 5'd2, 5'd1, 3'b000), 32'h100, 1'b1, 1'b1, 32'h110);
      fwd_sel1 = 2'b00; fwd_sel2 = 2'b10; mem_stage_to_reg = 1'b1;
      mem_rdata = 32'hFFFFFFFF; mem_alu_out = 32'h1;
      br_check("fwd_rdata", b_inst(13'h0010, 5'd2, 5'd1, 3'b000), 32'h100, 1'b1, 1'b1, 32'h110);
      mem_stage_to_reg = 1'b0;
      br_check("fwd_malu", b_inst(13'h0010, 5'd2, 5'd1, 3'b000), 32'h100, 1'b1, 1'b0, 32'h110);
      fwd_sel1 = 2'b11; fwd_sel2 = 2'b11; ex_alu_out = 32'h5; mem_alu_out = 32'h5;
      br_check("fwd_11", b_inst(13'h0010, 5'd2, 5'd1, 3'b000), 32'h100, 1'b1, 1'b0, 32'h110);
      fwd_sel1 = 2'b00; fwd_sel2 = 2'b00;

      @(negedge clk);
      if_valid = 1'b1; ctrl_sel = 1'b1; reg_write = 1'b0; imm_sel = 3'b011;
      if_inst = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1D, 7'b0100011};
      push(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFD, 5'd1, 5'd2, 5'h1D, 4'hA, 1'b0, 1'b0);
      @(negedge clk);
      sb_check("s_imm");
      reg_write = 1'b1; imm_sel = 3'b101; if_pc = 32'h100;
      if_inst = {1'b1, 10'h3F6, 1'b1, 8'hFF, 5'd1, 7'b1101111};
      #1 chk("j.pc", 64'(pc_branch), 64'(32'hEC));
      push(32'd31, 32'd13, 32'hFFFFFFEC, 5'd31, 5'd13, 5'd1, 4'hF, 1'b0, 1'b1);
      @(negedge clk);
      sb_check("j_imm");
      imm_sel = 3'b110; if_inst = {20'h80000, 5'd4, 7'b0110111};
      push(32'd0, 32'd0, 32'h80000000, 5'd0, 5'd0, 5'd4, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      sb_check("u_imm");
      imm_sel = 3'b111; if_inst = i_inst(12'h7FF, 5'd1, 3'b000, 5'd5, 7'b0010011);
      push(32'hFFFFFFFF, 32'd31, 32'd0, 5'd1, 5'd31, 5'd5, 4'h8, 1'b0, 1'b1);
      @(negedge clk);
      sb_check("sel111");

      imm_sel = 3'b001; if_inst = r_inst(5'd1, 5'd3, 5'd11, 3'b000);
      push(32'hDEADBEEF, 32'hFFFFFFFF, 32'd0, 5'd3, 5'd1, 5'd11, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      sb_check("stallA");
      ex_ready = 1'b0; if_inst = r_inst(5'd2, 5'd2, 5'd12, 3'b000);
      #1 chk("stall.idrdy0", 64'(id_ready), 64'(1'b0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall.d1",    64'(ex_data1), 64'(32'hDEADBEEF));
         chk("stall.rd",    64'(ex_rd),    64'(5'd11));
         chk("stall.valid", 64'(ex_valid), 64'(1'b1));
         chk("stall.idrdy", 64'(id_ready), 64'(1'b0));
         if_inst = r_inst(5'd2, 5'd2, 5'(13 + k), 3'b000);
      end
      ex_ready = 1'b1; if_inst = r_inst(5'd0, 5'd2, 5'd20, 3'b000);
      #1 chk("release.idrdy", 64'(id_ready), 64'(1'b1));
      push(32'd1, 32'd0, 32'd0, 5'd2, 5'd0, 5'd20, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      sb_check("stallE");

      imm_sel = 3'b010; mem_read = 1'b1; mem_to_reg = 1'b1; alu_src = 1'b1; flush = 1'b1;
      if_inst = i_inst(12'h004, 5'd3, 3'b010, 5'd6, 7'b0000011);
      @(negedge clk);
      chk("flush.valid", 64'(ex_valid),    64'(1'b0));
      chk("flush.mr",    64'(ex_mem_read), 64'(1'b0));
      flush = 1'b0;
      push(32'hDEADBEEF, 32'd4, 32'd4, 5'd3, 5'd4, 5'd6, 4'h2, 1'b1, 1'b1);
      @(negedge clk);
      sb_check("lw");
      chk("lw.m2r",  64'(ex_mem_to_reg), 64'(1'b1));
      chk("lw.asrc", 64'(ex_alu_src),    64'(1'b1));
      ex_ready = 1'b0; flush = 1'b1; if_inst = r_inst(5'd1, 5'd1, 5'd1, 3'b000);
      @(negedge clk);
      chk("sflush.valid", 64'(ex_valid),    64'(1'b0));
      chk("sflush.mr",    64'(ex_mem_read), 64'(1'b0));
      chk("sflush.d1",    64'(ex_data1),    64'(32'hDEADBEEF));
      chk("sflush.imm",   64'(ex_imm),      64'(32'd4));
      flush = 1'b0; ex_ready = 1'b1; ctrl_sel = 1'b0;
      if_inst = i_inst(12'h004, 5'd3, 3'b010, 5'd6, 7'b0000011);
      push(32'hDEADBEEF, 32'd4, 32'd4, 5'd3, 5'd4, 5'd6, 4'h2, 1'b0, 1'b0);
      @(negedge clk);
      sb_check("ctrl0");

      ctrl_sel = 1'b1; mem_read = 1'b0; mem_to_reg = 1'b0; alu_src = 1'b0; imm_sel = 3'b001;
      wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
      if_inst = r_inst(5'd0, 5'd7, 5'd13, 3'b000);
`ifdef REGFILE_BYPASS_EN
      push(32'h55, 32'd0, 32'd0, 5'd7, 5'd0, 5'd13, 4'h0, 1'b0, 1'b1);
`else
      push(32'd7, 32'd0, 32'd0, 5'd7, 5'd0, 5'd13, 4'h0, 1'b0, 1'b1);
`endif
      @(negedge clk);
      sb_check("x7same");
      wb_we = 1'b0;
      push(32'h55, 32'd0, 32'd0, 5'd7, 5'd0, 5'd13, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      sb_check("x7after");

      ex_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst.valid", 64'(ex_valid),     64'(1'b0));
      chk("arst.d1",    64'(ex_data1),     64'(32'h0));
      chk("arst.rd",    64'(ex_rd),        64'(5'd0));
      chk("arst.rw",    64'(ex_reg_write), 64'(1'b0));
      chk("sb.left",    64'(sbq.size()),   64'(0));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
